// File: rtl/unary_pkg.sv
// Shared types for the unary bounds ALU: runtime function select and control FSM states.
package unary_pkg;

  typedef enum logic [1:0] {
    MUL = 2'd0,
    AVG = 2'd1,
    MIN = 2'd2,
    MAX = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/unary_bound_fn.sv
// Combinational monotone function f(p, q) on unary counts, evaluated at double width.
module unary_bound_fn
  import unary_pkg::*;
#(
  parameter int LEN = 32,
  parameter int CW  = $clog2(LEN) + 1
) (
  input  logic [CW-1:0] i_p,
  input  logic [CW-1:0] i_q,
  input  logic [1:0]    i_mode,
  output logic [CW-1:0] o_f
);

  localparam int SH = $clog2(LEN);
  localparam logic [2*CW-1:0] LEN_W = (2*CW)'(LEN);

  logic [2*CW-1:0] w_p;
  logic [2*CW-1:0] w_q;
  logic [2*CW-1:0] w_full;

  // Every mode maps [0,LEN]^2 into [0,LEN]; the clamp only guards the narrowing.
  function automatic logic [CW-1:0] sat_len(input logic [2*CW-1:0] v);
    if (v > LEN_W) begin
      return LEN_W[CW-1:0];
    end
    return v[CW-1:0];
  endfunction

  always_comb begin
    w_p    = {{CW{1'b0}}, i_p};
    w_q    = {{CW{1'b0}}, i_q};
    w_full = '0;
    case (mode_e'(i_mode))
      MUL:     w_full = (w_p * w_q) >> SH;
      AVG:     w_full = (w_p + w_q) >> 1;
      MIN:     w_full = (w_p < w_q) ? w_p : w_q;
      MAX:     w_full = (w_p > w_q) ? w_p : w_q;
      default: w_full = '0;
    endcase
  end

  assign o_f = sat_len(w_full);

endmodule

// File: rtl/unary_bounds_alu.sv
// Bounds-tracking unary ALU: emits each result bit as soon as partial inputs guarantee it.
module unary_bounds_alu
  import unary_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int LOG2_LEN = $clog2(LEN),
  parameter int CW       = LOG2_LEN + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic       b,
  input  logic       b_valid,
  output logic       b_ready,
  output logic       y,
  output logic       y_valid,
  input  logic       y_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  state_e        r_state;
  state_e        w_state_nxt;
  mode_e         r_mode;
  logic [CW-1:0] r_a_ones, r_a_cnt, r_b_ones, r_b_cnt;
  logic [CW-1:0] r_y_ones, r_y_cnt;
  logic          r_y, r_y_valid, r_done;

  logic [CW-1:0] w_a_hi, w_b_hi, w_y_lo, w_y_hi, w_y_zeros, w_zero_room;
  logic          w_run, w_a_xfer, w_b_xfer, w_y_xfer, w_last_acc;
  logic          w_can_emit, w_emit_one, w_emit_zero;

  assign w_run = (r_state == RUN);

  // LEN is a power of two, so "count < LEN" is just the top counter bit being clear.
  assign a_ready = w_run && !r_a_cnt[LOG2_LEN] && !start;
  assign b_ready = w_run && !r_b_cnt[LOG2_LEN] && !start;

  assign w_a_xfer = a_valid && a_ready;
  assign w_b_xfer = b_valid && b_ready;
  assign w_y_xfer = r_y_valid && y_ready;

  assign w_a_hi = LEN_C - r_a_cnt + r_a_ones;
  assign w_b_hi = LEN_C - r_b_cnt + r_b_ones;

  unary_bound_fn #(.LEN(LEN), .CW(CW)) u_fn_lo (
    .i_p   (r_a_ones),
    .i_q   (r_b_ones),
    .i_mode(r_mode),
    .o_f   (w_y_lo)
  );

  unary_bound_fn #(.LEN(LEN), .CW(CW)) u_fn_hi (
    .i_p   (w_a_hi),
    .i_q   (w_b_hi),
    .i_mode(r_mode),
    .o_f   (w_y_hi)
  );

  assign w_y_zeros   = r_y_cnt - r_y_ones;
  assign w_zero_room = LEN_C - w_y_hi;
  assign w_can_emit  = w_run && !start && (!r_y_valid || y_ready) && !r_y_cnt[LOG2_LEN];
  assign w_emit_one  = w_can_emit && (r_y_ones < w_y_lo);
  assign w_emit_zero = w_can_emit && !w_emit_one && (w_y_zeros < w_zero_room);

  // The LEN-th bit is the one sitting in the output register once y_cnt has reached LEN.
  assign w_last_acc = w_run && !start && w_y_xfer && r_y_cnt[LOG2_LEN];

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = RUN;
    end else if (w_last_acc) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= MUL;
      r_a_ones  <= '0;
      r_a_cnt   <= '0;
      r_b_ones  <= '0;
      r_b_cnt   <= '0;
      r_y_ones  <= '0;
      r_y_cnt   <= '0;
      r_y       <= 1'b0;
      r_y_valid <= 1'b0;
      r_done    <= 1'b0;
    end else if (start) begin
      r_mode    <= mode_e'(mode);
      r_a_ones  <= '0;
      r_a_cnt   <= '0;
      r_b_ones  <= '0;
      r_b_cnt   <= '0;
      r_y_ones  <= '0;
      r_y_cnt   <= '0;
      r_y       <= 1'b0;
      r_y_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_a_xfer) begin
        r_a_cnt  <= r_a_cnt + CW'(1);
        r_a_ones <= r_a_ones + {{(CW-1){1'b0}}, a};
      end
      if (w_b_xfer) begin
        r_b_cnt  <= r_b_cnt + CW'(1);
        r_b_ones <= r_b_ones + {{(CW-1){1'b0}}, b};
      end
      if (w_emit_one || w_emit_zero) begin
        r_y       <= w_emit_one;
        r_y_valid <= 1'b1;
        r_y_cnt   <= r_y_cnt + CW'(1);
        r_y_ones  <= r_y_ones + {{(CW-1){1'b0}}, w_emit_one};
      end else if (w_y_xfer) begin
        r_y_valid <= 1'b0;
      end
      r_done <= w_last_acc;
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign busy    = w_run;
  assign done    = r_done;

endmodule

// File: tb/tb_unary_bounds_alu.sv
// Randomized bench for unary_bounds_alu at LEN=8 (index 0) and LEN=32 (index 1).
module tb_unary_bounds_alu;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start   [2];
  logic [1:0] mode    [2];
  logic       a       [2];
  logic       a_valid [2];
  logic       a_ready [2];
  logic       b       [2];
  logic       b_valid [2];
  logic       b_ready [2];
  logic       y       [2];
  logic       y_valid [2];
  logic       y_ready [2];
  logic       busy    [2];
  logic       done    [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  unary_bounds_alu #(.LEN(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start[0]), .mode(mode[0]),
    .a(a[0]), .a_valid(a_valid[0]), .a_ready(a_ready[0]),
    .b(b[0]), .b_valid(b_valid[0]), .b_ready(b_ready[0]),
    .y(y[0]), .y_valid(y_valid[0]), .y_ready(y_ready[0]),
    .busy(busy[0]), .done(done[0])
  );

  unary_bounds_alu #(.LEN(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start[1]), .mode(mode[1]),
    .a(a[1]), .a_valid(a_valid[1]), .a_ready(a_ready[1]),
    .b(b[1]), .b_valid(b_valid[1]), .b_ready(b_ready[1]),
    .y(y[1]), .y_valid(y_valid[1]), .y_ready(y_ready[1]),
    .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference: the final count of ones is f applied to the operand one-counts.
  function automatic int ref_f(input int md, input int p, input int q, input int len);
    case (md)
      0:       return (p * q) / len;
      1:       return (p + q) / 2;
      2:       return (p < q) ? p : q;
      default: return (p > q) ? p : q;
    endcase
  endfunction

  function automatic logic [31:0] make_stream(input int len, input int ones);
    logic [31:0] s = '0;
    int pos;
    for (int i = 0; i < ones; i++) begin
      do pos = $urandom_range(len - 1); while (s[pos]);
      s[pos] = 1'b1;
    end
    return s;
  endfunction

  task automatic check_idle(input int k, input string tag);
    check({tag, "_y_valid"}, y_valid[k], 0);
    check({tag, "_y"},       y[k],       0);
    check({tag, "_busy"},    busy[k],    0);
    check({tag, "_done"},    done[k],    0);
    check({tag, "_a_ready"}, a_ready[k], 0);
    check({tag, "_b_ready"}, b_ready[k], 0);
  endtask

  // Runs one frame; stop_after > 0 abandons it once that many result bits were accepted.
  task automatic run_frame(input int k, input int md, input int na, input int nb,
                           input bit feed_b, input int gap, input int stall,
                           input int stop_after);
    int len = (k == 0) ? 8 : 32;
    logic [31:0] abits = make_stream(len, na);
    logic [31:0] bbits = make_stream(len, nb);
    int ai = 0, bi = 0, yo = 0, y1 = 0, dn = 0, cyc = 0, viol = 0;
    bit a_x, b_x, held = 0, busy_at_done = 1;
    logic held_y = 1'b0;
    int expv = feed_b ? ref_f(md, na, nb, len) : ref_f(md, na, (md == 2) ? len : 0, len);

    @(posedge clk); #1;
    start[k] = 1'b1; mode[k] = 2'(md); a_valid[k] = 1'b0; b_valid[k] = 1'b0;
    @(negedge clk);
    check("ready_on_start", a_ready[k], 0);
    @(posedge clk); #1;
    start[k] = 1'b0;
    mode[k] = 2'($urandom);
    check("busy_after_start", busy[k], 1);
    while (cyc < 3000) begin
      a_valid[k] = (ai < len) && ($urandom_range(99) >= gap);
      a[k]       = (ai < len) ? abits[ai] : 1'b0;
      b_valid[k] = feed_b && (bi < len) && ($urandom_range(99) >= gap);
      b[k]       = (bi < len) ? bbits[bi] : 1'b0;
      y_ready[k] = ($urandom_range(99) >= stall);
      @(negedge clk);
      if (held && !(y_valid[k] && y[k] == held_y)) viol++;
      a_x = a_valid[k] && a_ready[k];
      b_x = b_valid[k] && b_ready[k];
      if (y_valid[k] && y_ready[k]) begin
        yo++;
        if (y[k]) y1++;
      end
      held   = y_valid[k] && !y_ready[k];
      held_y = y[k];
      if (done[k]) begin
        dn++;
        busy_at_done = busy[k];
      end
      @(posedge clk); #1;
      if (a_x) ai++;
      if (b_x) bi++;
      if (stop_after > 0 && yo >= stop_after) break;
      if (dn > 0) break;
      cyc++;
    end
    a_valid[k] = 1'b0; b_valid[k] = 1'b0;
    check("stable_under_stall", viol, 0);
    if (stop_after > 0) begin
      check("no_done_in_aborted", dn, 0);
      check("aborted_out_count", yo, stop_after);
    end else begin
      check("frame_timeout", (cyc >= 3000) ? 1 : 0, 0);
      check("ones_count", y1, expv);
      check("bit_count", yo, len);
      check("done_count", dn, 1);
      check("busy_at_done", busy_at_done, 0);
      if (!feed_b) check("b_unconsumed", bi, 0);
      @(negedge clk);
      check("done_single_pulse", done[k], 0);
      check("b_ready_after_done", b_ready[k], 0);
      check("a_ready_after_done", a_ready[k], 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start[k] = 0; mode[k] = 0; a[k] = 0; a_valid[k] = 0;
      b[k] = 0; b_valid[k] = 0; y_ready[k] = 1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst8");
    check_idle(1, "rst32");
    #1 reset = 1'b1;

    run_frame(0, 0, 6, 4, 1, 0, 0, 0);     // MUL 6*4/8 = 3
    run_frame(0, 2, 0, 0, 0, 0, 0, 0);     // MIN, all-zero A, B withheld
    run_frame(0, 3, 8, 0, 0, 0, 0, 0);     // MAX, all-one A, B withheld
    run_frame(1, 1, 20, 11, 1, 30, 40, 0); // AVG (20+11)/2 = 15

    for (int t = 0; t < 8; t++) begin
      int k = $urandom_range(1);
      int len = (k == 0) ? 8 : 32;
      run_frame(k, $urandom_range(3), $urandom_range(len), $urandom_range(len),
                1, $urandom_range(50), $urandom_range(50), 0);
    end

    run_frame(1, 0, 0, 32, 1, 0, 0, 5);    // abandoned after 5 bits
    run_frame(1, 0, 32, 32, 1, 10, 20, 0); // restart: 32 ones

    run_frame(1, 3, 32, 16, 1, 0, 0, 5);
    #2 reset = 1'b0;
    #1;
    check_idle(1, "rst_mid");
    @(posedge clk); #1 reset = 1'b1;
    run_frame(1, 1, 25, 7, 1, 20, 20, 0);  // clean frame after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unary_bounds_alu.md
# unary_bounds_alu

Parametrised successor to the two-input bounds-tracking unary multiplier. It consumes two unary bitstreams of length LEN and emits a length-LEN unary result for a runtime-selected monotone function: multiply, scaled add, min or max. Each output bit is produced as soon as the partially received inputs guarantee it. The block sits between unary stream producers and consumers in the unary datapath. It replaces the fixed multiplier with a framed start/done protocol and valid/ready handshakes on both input channels and the output.

## Interface
- LEN, 32: stream length in bits; must be a power of two, ≥ 2.
- LOG2_LEN, $clog2(LEN): derived.
- CW, LOG2_LEN+1: counter width; holds values 0..LEN.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; clears the frame and latches mode.
- mode  in  2  unary_pkg::mode_e: MUL=0, AVG=1, MIN=2, MAX=3.
- a, a_valid  in  1,1  operand A bit and its valid.
- a_ready  out  1  high when busy, a_cnt < LEN and !start.
- b, b_valid  in  1,1  operand B bit and its valid; symmetric to A.
- b_ready  out  1  symmetric to a_ready.
- y, y_valid  out  1,1  result bit and its valid.
- y_ready  in  1  result consumer ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the LEN-th result bit is accepted.

## Operation
- Per-channel state: x_ones and x_cnt (CW bits). A transfer occurs when x_valid && x_ready; x_cnt increments and x_ones increments by the bit value.
- Bounds:
  - x_lo = x_ones.
  - x_hi = LEN - x_cnt + x_ones.
- f(p,q) is evaluated at a width of 2*CW before truncation to CW:
  - MUL: (p*q) >> LOG2_LEN.
  - AVG: (p+q) >> 1.
  - MIN: min(p,q).
  - MAX: max(p,q).
- f is nondecreasing in both arguments, so:
  - y_lo = f(a_lo, b_lo).
  - y_hi = f(a_hi, b_hi).
- Output state: y_ones and y_cnt (CW bits). Emitted zeros = y_cnt - y_ones.
- Emit decision, evaluated on registered state only when the output slot is free (!y_valid || y_ready) and y_cnt < LEN:
  - y_ones < y_lo: emit 1.
  - else if (y_cnt - y_ones) < LEN - y_hi: emit 0.
  - else: stall, no emission.
  - Ones take priority over zeros.
- When both inputs are complete, y_lo == y_hi, so the frame always finishes and the result holds exactly f(a_final, b_final) ones.
- The total result is never more than LEN bits. The count of ones never exceeds y_hi and the count of zeros never exceeds LEN - y_lo.
- FSM:
  - IDLE to RUN on start.
  - RUN to IDLE when the LEN-th output bit is accepted; done pulses on that edge.
  - start in RUN aborts the frame and restarts it: counters clear, the pending y is dropped, and mode is re-latched.
  - start while IDLE with no frame pending: legal.
- Mode changes outside start are ignored.

## Timing
- Reset values: y=0, y_valid=0, busy=0, done=0, all counters 0, state IDLE. a_ready and b_ready are 0 because busy=0.
- start at edge n:
  - busy=1 from n.
  - Inputs on the start cycle are not accepted because ready is gated by !start.
- Latency:
  - An input accepted at edge n updates the bounds after n.
  - The earliest y_valid that depends on it appears at edge n+1.
  - Bits already guaranteed at start emit from the first RUN edge, e.g. MUL with a known all-zero operand.
- Output handshake:
  - y and y_valid are held stable while y_valid && !y_ready.
  - A transfer and a new emission can occur on the same edge, giving one bit per cycle.
- Input and output transfers on the same edge are independent. Bounds use pre-edge counts.
- The asynchronous reset asserted mid-frame clears everything immediately. No done is produced.
- Both inputs complete plus output backpressure: inputs stop (ready=0) and the output drains at the consumer's rate.

## Structure
- unary_pkg: mode_e enum, state_e {IDLE, RUN}.
- Sub-module unary_bound_fn: combinational f(p, q, mode) with parameters LEN and CW. It is instantiated twice, once for the lo bound and once for the hi bound.
- Top level: channel counters, output counters, emit logic, FSM and the output register.

## Test plan
- MUL, LEN=8, A=6 ones (11111100), B=4 ones (11110000), both fed 1 bit/cycle, y_ready=1 -> exactly 3 ones in 8 y bits, done once, busy drops.
- MIN, LEN=8, A=all zeros fed first and B withheld -> 8 zeros emitted with no B input; done asserted; b_ready falls with busy.
- MAX, LEN=8, A=all ones -> 8 ones emitted while B is unconsumed; ones-before-zeros priority holds with mixed bounds.
- AVG, LEN=32, A=20, B=11, random valid gaps and random y_ready -> 15 ones. y/y_valid are stable under stall; no bit is lost or duplicated.
- start pulsed mid-frame after 5 outputs, then MUL A=B=all ones -> 32 ones counted from the restart only; no done from the aborted frame.
- reset dropped mid-frame -> all outputs at reset values within the same cycle; the next start runs a clean frame.
